// File: rtl/flash_pkg.sv
// flash_pkg: command codes, bus timing constants and FSM states shared by the flash writer
package flash_pkg;
   localparam logic [7:0] CMD_WREN  = 8'h06;
   localparam logic [7:0] CMD_SE    = 8'h20;
   localparam logic [7:0] CMD_PP    = 8'h02;
   localparam logic [7:0] CMD_RDSR  = 8'h05;
   localparam logic [7:0] CMD_DREAD = 8'hBB;
   localparam int EXIT_LEN = 16;
   localparam int CS_GAP   = 2;
   typedef enum logic [3:0] {
      IDLE, WAIT_GNT, EXIT, EXIT_GAP, WREN, WREN_GAP, CMD, ADDR, DATA,
      END_CMD, POLL_CMD, POLL, FINISH
   } state_t;
endpackage

// File: rtl/spi_shift_out.sv
// spi_shift_out: MSB-first loadable 8/24-bit shifter with bit counter and last-bit flag
module spi_shift_out (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        wide,
   input  logic [23:0] data,
   input  logic        shift,
   output logic        dout,
   output logic        last
);
   logic [23:0] sr;
   logic [4:0]  cnt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         sr  <= '1;
         cnt <= '0;
      end else if (load) begin
         sr  <= wide ? data : {data[7:0], 16'h0};
         cnt <= wide ? 5'd23 : 5'd7;
      end else if (shift) begin
         sr  <= {sr[22:0], 1'b0};
         cnt <= cnt - 5'd1;
      end
   assign dout = sr[23];
   assign last = cnt == '0;
endmodule

// File: rtl/flash_writer.sv
// flash_writer: W25Q64FV sector-erase / page-program engine sharing the read engine's SPI pins
module flash_writer
   import flash_pkg::*;
#(
   parameter logic [23:0] POLL_MAX   = 24'd4_000_000,
   parameter int          SAMPLE_DLY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        op,
   input  logic [23:0] address,
   input  logic [8:0]  len,
   input  logic [7:0]  wdata,
   output logic        wdata_req,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        gnt,
   output logic        oe,
   output logic        mspi_cs,
   output logic        mspi_di,
   input  logic        mspi_do,
   output logic        mspi_hold,
   output logic        mspi_wp
);
   state_t state, nxt;
   logic op_q, err_q, ld, wide, shift, sr_out, sr_last, accept, bad, decide, gap_end;
   logic [23:0] addr_q, ld_data, polls;
   logic [8:0] len_q, rem;
   logic [4:0] cnt;
   logic [2:0] slot;
   logic [SAMPLE_DLY-1:0] pipe;

   assign bad     = op && (len == '0 || len > 9'd256);
   assign accept  = req && (state == IDLE || state == FINISH);
   assign decide  = state == POLL && pipe[SAMPLE_DLY-1];
   assign gap_end = cnt == 5'(CS_GAP - 1);

   always_comb begin
      nxt = state;
      ld = 1'b0;
      wide = 1'b0;
      shift = 1'b0;
      wdata_req = 1'b0;
      ld_data = {16'h0, CMD_WREN};
      unique case (state)
         IDLE, FINISH: nxt = accept ? (bad ? FINISH : WAIT_GNT) : IDLE;
         WAIT_GNT: nxt = gnt ? EXIT : WAIT_GNT;
         EXIT: nxt = cnt == 5'(EXIT_LEN - 1) ? EXIT_GAP : EXIT;
         EXIT_GAP: begin
            ld = gap_end;
            nxt = gap_end ? WREN : EXIT_GAP;
         end
         WREN: begin
            shift = 1'b1;
            nxt = sr_last ? WREN_GAP : WREN;
         end
         WREN_GAP: begin
            ld = gap_end;
            ld_data = {16'h0, op_q ? CMD_PP : CMD_SE};
            nxt = gap_end ? CMD : WREN_GAP;
         end
         CMD: begin
            shift = 1'b1;
            ld = sr_last;
            wide = 1'b1;
            ld_data = addr_q;
            nxt = sr_last ? ADDR : CMD;
         end
         // the byte after the current one is fetched in its last bit slot
         ADDR: begin
            shift = 1'b1;
            ld = sr_last && op_q;
            wdata_req = ld;
            ld_data = {16'h0, wdata};
            nxt = sr_last ? (op_q ? DATA : END_CMD) : ADDR;
         end
         DATA: begin
            shift = 1'b1;
            ld = sr_last && rem != '0;
            wdata_req = ld;
            ld_data = {16'h0, wdata};
            nxt = sr_last && rem == '0 ? END_CMD : DATA;
         end
         END_CMD: begin
            ld = gap_end;
            ld_data = {16'h0, CMD_RDSR};
            nxt = gap_end ? POLL_CMD : END_CMD;
         end
         POLL_CMD: begin
            shift = 1'b1;
            nxt = sr_last ? POLL : POLL_CMD;
         end
         POLL: nxt = decide && (!mspi_do || polls == POLL_MAX - 24'd1) ? FINISH : POLL;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state  <= IDLE;
         op_q   <= 1'b0;
         err_q  <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         rem    <= '0;
         cnt    <= '0;
         slot   <= '0;
         polls  <= '0;
         pipe   <= '0;
      end else begin
         state <= nxt;
         cnt   <= nxt != state ? '0 : cnt + 5'd1;
         slot  <= state == POLL ? slot + 3'd1 : '0;
         // WIP (bit 0) arrives SAMPLE_DLY cycles after the 8th slot of each status byte
         pipe[0] <= state == POLL && slot == 3'd7;
         for (int i = 1; i < SAMPLE_DLY; i++) pipe[i] <= pipe[i-1];
         polls <= state != POLL ? '0 : polls + 24'(decide);
         rem   <= state == ADDR ? len_q - 9'd1 : rem - 9'(wdata_req);
         if (accept) {op_q, addr_q, len_q, err_q} <= {op, address, len, bad};
         else if (decide) err_q <= mspi_do;
      end

   spi_shift_out u_sh (
      .clk   (clk),
      .resetn(resetn),
      .load  (ld),
      .wide  (wide),
      .data  (ld_data),
      .shift (shift),
      .dout  (sr_out),
      .last  (sr_last)
   );

   assign busy      = !(state inside {IDLE, FINISH});
   assign done      = state == FINISH;
   assign error     = done && err_q;
   assign oe        = !(state inside {IDLE, WAIT_GNT, FINISH});
   assign mspi_cs   = !(state inside {EXIT, WREN, CMD, ADDR, DATA, POLL_CMD, POLL});
   assign mspi_di   = state inside {WREN, CMD, ADDR, DATA, POLL_CMD} ? sr_out : 1'b1;
   assign mspi_hold = 1'b1;
   assign mspi_wp   = 1'b1;
endmodule

// File: tb/tb_flash_writer.sv
// tb_flash_writer: directed erase/program vectors against a small W25Q64FV bus monitor and status model
module tb_flash_writer;
   logic clk = 1'b0, resetn = 1'b0, req = 1'b0, op = 1'b0, gnt = 1'b1, mspi_do = 1'b1;
   logic [23:0] address = '0;
   logic [8:0] len = '0;
   logic [7:0] wdata;
   logic wdata_req, busy, done, error, oe, mspi_cs, mspi_di, mspi_hold, mspi_wp;
   logic [7:0] wd [0:255];
   int widx = 0, wbase = 0, n_cmp = 0, n_bad = 0, wip_n = 0, slot = 0, hrun = 0, act = 0;
   logic take = 1'b0, nd = 1'b1;
   logic [7:0] sh = '0, fb = '0;
   logic [7:0] bytes_q[$];
   int flen_q[$], gap_q[$], wpos_q[$];

   flash_writer #(.POLL_MAX(24'd10), .SAMPLE_DLY(1)) dut (
      .clk(clk), .resetn(resetn), .req(req), .op(op), .address(address), .len(len),
      .wdata(wdata), .wdata_req(wdata_req), .busy(busy), .done(done), .error(error),
      .gnt(gnt), .oe(oe), .mspi_cs(mspi_cs), .mspi_di(mspi_di), .mspi_do(mspi_do),
      .mspi_hold(mspi_hold), .mspi_wp(mspi_wp)
   );

   always #5 clk = ~clk;
   assign wdata = wd[8'(widx - wbase)];

   // flash side: collect bytes per cs-low frame and answer RDSR with WIP for wip_n bytes
   always @(negedge clk) begin
      logic [7:0] b, st;
      int k;
      b = {sh[6:0], mspi_di};
      k = slot >= 8 ? slot - 8 : 0;
      st = (k / 8 < wip_n) ? 8'h03 : 8'h00;
      take <= wdata_req;
      if (oe || !mspi_cs) act <= act + 1;
      if (!mspi_cs) begin
         sh <= b;
         if (slot % 8 == 7) bytes_q.push_back(b);
         if (slot == 7) fb <= b;
         if (wdata_req) wpos_q.push_back(slot);
         if (hrun != 0) gap_q.push_back(hrun);
         hrun <= 0;
         slot <= slot + 1;
         nd <= (slot >= 8 && fb == 8'h05) ? st[7 - k % 8] : 1'b1;
      end else begin
         if (slot != 0) flen_q.push_back(slot);
         slot <= 0;
         hrun <= oe ? hrun + 1 : 0;
         nd <= 1'b1;
      end
   end

   always @(posedge clk) begin
      mspi_do <= nd;
      if (take) widx <= widx + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(output int cyc, output logic [2:0] snap);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", done, 1);
      snap = {error, mspi_cs, oe};
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input logic o, input logic [23:0] a, input logic [8:0] l, input int w,
                      output int cyc, output logic [2:0] snap);
      @(negedge clk);
      op = o;
      address = a;
      len = l;
      wip_n = w;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      op = ~o;
      address = '0;
      len = '0;
      wait_done(cyc, snap);
   endtask

   initial begin
      int cyc, errs, f, b, g, p, v;
      int bl [2];
      logic [2:0] snap;
      bl = '{0, 257};
      repeat (3) @(negedge clk);
      check("reset_outs", {busy, done, error, wdata_req, oe, mspi_cs, mspi_di}, 7'b0000011);
      resetn = 1'b1;
      @(negedge clk);

      f = flen_q.size(); b = bytes_q.size(); g = gap_q.size(); wbase = widx;
      run(1'b0, 24'h123456, 9'd0, 3, cyc, snap);
      check("se_snap", snap, 3'b010);
      check("se_frames", flen_q.size() - f, 4);
      check("se_exit_len", flen_q[f], 16);
      check("se_wren_len", flen_q[f+1], 8);
      check("se_cmd_len", flen_q[f+2], 32);
      check("se_status_bytes", (flen_q[f+3] - 8) / 8, 4);
      check("se_bytes_a", {bytes_q[b], bytes_q[b+1], bytes_q[b+2], bytes_q[b+3]}, 32'hFFFF0620);
      check("se_bytes_b", {bytes_q[b+4], bytes_q[b+5], bytes_q[b+6], bytes_q[b+7]}, 32'h12345605);
      check("se_gaps", {8'(gap_q[g]), 8'(gap_q[g+1]), 8'(gap_q[g+2])}, 24'h020202);
      check("se_pulses", widx - wbase, 0);

      wd[0] = 8'hA5; wd[1] = 8'h5A; wd[2] = 8'hFF;
      f = flen_q.size(); b = bytes_q.size(); p = wpos_q.size(); wbase = widx;
      run(1'b1, 24'h001000, 9'd3, 0, cyc, snap);
      check("pp3_snap", snap, 3'b010);
      check("pp3_pulses", widx - wbase, 3);
      check("pp3_frames", flen_q.size() - f, 4);
      check("pp3_cmd_len", flen_q[f+2], 56);
      check("pp3_status_bytes", (flen_q[f+3] - 8) / 8, 1);
      check("pp3_bytes_a", {bytes_q[b], bytes_q[b+1], bytes_q[b+2], bytes_q[b+3]}, 32'hFFFF0602);
      check("pp3_bytes_b", {bytes_q[b+4], bytes_q[b+5], bytes_q[b+6], bytes_q[b+7]}, 32'h001000A5);
      check("pp3_bytes_c", {bytes_q[b+8], bytes_q[b+9], bytes_q[b+10]}, 24'h5AFF05);
      check("pp3_wreq_slots", {8'(wpos_q[p]), 8'(wpos_q[p+1]), 8'(wpos_q[p+2])}, {8'd31, 8'd39, 8'd47});

      for (int i = 0; i < 256; i++) wd[i] = 8'(i) ^ 8'h3C;
      f = flen_q.size(); b = bytes_q.size(); p = wpos_q.size(); wbase = widx;
      run(1'b1, 24'h002000, 9'd256, 2, cyc, snap);
      check("pp256_snap", snap, 3'b010);
      check("pp256_pulses", widx - wbase, 256);
      check("pp256_cmd_len", flen_q[f+2], 2080);
      check("pp256_status_bytes", (flen_q[f+3] - 8) / 8, 3);
      check("pp256_last_wreq_slot", wpos_q[p+255], 2071);
      errs = 0;
      for (int i = 0; i < 256; i++) if (bytes_q[b+7+i] !== wd[i]) errs++;
      check("pp256_data_errs", errs, 0);

      foreach (bl[j]) begin
         v = act;
         run(1'b1, 24'h000100, 9'(bl[j]), 0, cyc, snap);
         check("bad_len_latency", cyc, 0);
         check("bad_len_snap", snap, 3'b110);
         check("bad_len_bus_activity", act - v, 0);
      end

      f = flen_q.size();
      run(1'b0, 24'hABC000, 9'd0, 1000, cyc, snap);
      check("stuck_snap", snap, 3'b110);
      check("stuck_status_bytes", (flen_q[f+3] - 8) / 8, 10);

      gnt = 1'b0;
      wip_n = 0;
      f = flen_q.size(); b = bytes_q.size(); v = act;
      @(negedge clk);
      op = 1'b0; address = 24'h040000; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
      op = 1'b1; len = 9'd0; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (44) @(negedge clk);
      check("gnt_wait_activity", act - v, 0);
      check("gnt_wait_busy_done", {busy, done}, 2'b10);
      gnt = 1'b1;
      wait_done(cyc, snap);
      check("gnt_snap", snap, 3'b010);
      check("gnt_cmd_bytes", {bytes_q[b+3], bytes_q[b+4], bytes_q[b+5], bytes_q[b+6]}, 32'h20040000);

      wbase = widx;
      @(negedge clk);
      op = 1'b1; address = 24'h003000; len = 9'd4; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      cyc = 0;
      while (!wdata_req && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_wreq_seen", wdata_req, 1);
      repeat (5) @(negedge clk);
      check("rst_in_data", {mspi_cs, oe, busy}, 3'b011);
      #2 resetn = 1'b0;
      #1 check("rst_async", {busy, mspi_cs, oe, done, wdata_req}, 5'b01000);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_idle", {busy, mspi_cs, oe, mspi_di}, 4'b0101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/flash_writer.md
# flash_writer

SPI-mode erase/program engine for the W25Q64FV 64 Mbit configuration flash, sharing the same pins as the dual-IO read engine. It first forces the flash out of continuous-read mode, then issues Write Enable, either Sector Erase (4 KB) or Page Program (1–256 bytes), and polls the status register until the internal write completes. It is used to persist settings and disk images; an external arbiter grants pin ownership between reader and writer.

## Interface
Parameters:
- POLL_MAX, 24'd4_000_000, maximum status bytes polled before error
- SAMPLE_DLY, 1, clk cycles between a bit slot and the sampling of mspi_do for that slot

Ports:
- clk  in  1  system clock; SCLK to flash is derived from clk outside this block, one bit per clk
- resetn  in  1  reset, asynchronous, active-low
- req  in  1  start pulse, accepted only when busy=0
- op  in  1  0 = sector erase (0x20), 1 = page program (0x02); latched on req
- address  in  24  byte address; latched on req; erase ignores address[11:0] (sent as-is, flash masks)
- len  in  9  program byte count, 1..256; latched on req
- wdata  in  8  program byte, valid whenever wdata_req=1 (show-ahead source)
- wdata_req  out  1  one-cycle pulse; wdata consumed on the same edge
- busy  out  1  high from accepted req until done
- done  out  1  one-cycle pulse at end of operation
- error  out  1  valid with done: bad len or poll timeout
- gnt  in  1  pin ownership from arbiter
- oe  out  1  block drives mspi_* only when oe=1
- mspi_cs  out  1  chip select, active-low
- mspi_di  out  1  IO0, serial data to flash
- mspi_do  in  1  IO1, serial data from flash
- mspi_hold, mspi_wp  out  1  static 1 and 1 while oe (WP high to allow writes)

## Operation
- Reset: busy=0, done=0, error=0, wdata_req=0, oe=0, mspi_cs=1, mspi_di=1, state IDLE.
- Bad request (op=1 and len=0 or len>256): no bus activity, done+error next cycle.
- States and transitions:
 - IDLE → WAIT_GNT on valid req.
 - WAIT_GNT: oe=0 until gnt=1, then oe=1 → EXIT.
 - EXIT: cs low 16 cycles, mspi_di=1 (clears M4, leaves continuous read); cs high 2 cycles → WREN.
 - WREN: cs low, shift 0x06 MSB first, 8 cycles; cs high 2 cycles → CMD.
 - CMD: shift 0x20/0x02 (8), then address[23:0] (24), MSB first → DATA if program, else END_CMD.
 - DATA: len×8 cycles, each byte MSB first.
 - END_CMD: cs high 2 cycles → POLL.
 - POLL: cs low, shift 0x05 (8), then read status bytes continuously with cs held low; after each byte, WIP=bit0; WIP=0 → FINISH; byte count reaches POLL_MAX → FINISH with error.
 - FINISH: cs high, oe=0, done pulse, busy=0 → IDLE.
- gnt dropping mid-operation is illegal; block ignores it and keeps ownership until done.
- req while busy ignored. resetn mid-operation: immediate return to reset values (cs released asynchronously).

## Timing
- Outputs update on rising clk; one bit slot = one clk.
- Erase: 18 (EXIT) + 10 (WREN) + 32 + 2 + 8 + 8·n poll bytes, done one cycle after cs rises.
- Program: as erase plus 8·len data cycles.
- wdata_req: first pulse in the last address-bit cycle; subsequent pulses in the last bit cycle of each data byte except the final one; exactly len pulses.
- Status bit sampled SAMPLE_DLY cycles after its slot; WIP decision made SAMPLE_DLY cycles after the 8th slot of a byte while further slots continue (extra clocks harmless).

## Structure
- Shared package flash_pkg: command constants (0x06, 0x20, 0x02, 0x05, 0xBB), state enum, EXIT_LEN=16, CS_GAP=2.
- One sub-module natural: spi_shift_out (8/24-bit MSB-first loadable shifter with bit counter and last-bit flag).

## Test plan
- Erase at 0x123456, flash model WIP=1 for 3 bytes → mspi_di shows 16 ones, 0x06, 0x20 0x12 0x34 0x56, 0x05; done after 4th status byte, error=0.
- Program len=3 at 0x001000, wdata A5,5A,FF → exactly 3 wdata_req pulses, bytes on IO0 match, done error=0.
- Program len=256 → 256 pulses, 2048 data cycles, cs never high between address and last data bit.
- len=0 and len=257 → done+error one cycle after req, mspi_cs stays 1, oe stays 0.
- WIP stuck 1 with POLL_MAX=10 → done+error after 10 status bytes, cs high.
- gnt held low 50 cycles after req → oe=0, cs=1 throughout; resetn asserted mid-DATA → cs=1, busy=0 immediately.
